// File: rtl/classificador_medida_n.sv
// classificador_medida_n: collects N samples, divides the sum by N and classifies the mean against three thresholds.
module classificador_medida_n #(
  parameter int LARGURA    = 12,
  parameter int N_AMOSTRAS = 3,
  parameter int MAX_DIFF   = 4
) (
  input  logic               clock,
  input  logic               zera,
  input  logic               iniciar,
  input  logic               medida_valida,
  input  logic [LARGURA-1:0] medida,
  input  logic [LARGURA-1:0] nv_baixo,
  input  logic [LARGURA-1:0] nv_alto,
  input  logic [LARGURA-1:0] nv_crit,
  output logic [LARGURA-1:0] media,
  output logic [2:0]         medida_classificacao,
  output logic               descartar_medida,
  output logic               fim_classificacao,
  output logic               ocupado
);
  localparam int SOMA_W = LARGURA + $clog2(N_AMOSTRAS + 1);
  localparam int SW1 = SOMA_W + 1;
  localparam int CW = $clog2(N_AMOSTRAS + 1);
  localparam int PW = $clog2(SOMA_W + 1);
  localparam logic [SOMA_W:0] DIVISOR = SW1'(N_AMOSTRAS);
  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(MAX_DIFF);
  localparam logic [2:0] OCIOSO = 3'd0;
  localparam logic [2:0] COLETA = 3'd1;
  localparam logic [2:0] DIVIDE = 3'd2;
  localparam logic [2:0] CLASSIFICA = 3'd3;
  localparam logic [2:0] FIM = 3'd4;
  logic [2:0] estado;
  logic [SOMA_W-1:0] soma, quoc, resto;
  logic [SOMA_W:0] resto_sh;
  logic [CW-1:0] cont;
  logic [PW-1:0] passo;
  logic [LARGURA-1:0] maior, menor, media_nova;
  logic cabe;
  logic [2:0] classe;
  // quoc starts as the dividend and shifts quotient bits in from the right
  always_comb begin
    resto_sh = {resto, quoc[SOMA_W-1]};
    cabe = resto_sh >= DIVISOR;
    media_nova = quoc[LARGURA-1:0];
    classe = (media_nova > nv_baixo) ? 3'b001 :
             (media_nova > nv_alto && media_nova <= nv_baixo) ? 3'b100 :
             (media_nova >= nv_crit && media_nova <= nv_alto) ? 3'b010 : 3'b011;
  end
  assign ocupado = (estado == COLETA) || (estado == DIVIDE) || (estado == CLASSIFICA);
  always_ff @(posedge clock) begin
    if (zera) begin
      estado <= OCIOSO;
      soma <= '0;
      quoc <= '0;
      resto <= '0;
      cont <= '0;
      passo <= '0;
      maior <= '0;
      menor <= '0;
      media <= '0;
      medida_classificacao <= 3'b000;
      descartar_medida <= 1'b0;
      fim_classificacao <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          fim_classificacao <= 1'b0;
          if (iniciar) begin
            estado <= COLETA;
            soma <= '0;
            cont <= '0;
            maior <= '0;
            menor <= '1;
          end
        end
        COLETA: if (medida_valida) begin
          soma <= soma + SOMA_W'(medida);
          cont <= cont + CW'(1);
          maior <= (medida > maior) ? medida : maior;
          menor <= (medida < menor) ? medida : menor;
          if (cont == CW'(N_AMOSTRAS - 1)) begin
            estado <= DIVIDE;
            quoc <= soma + SOMA_W'(medida);
            resto <= '0;
            passo <= '0;
          end
        end
        DIVIDE: begin
          resto <= SOMA_W'(cabe ? resto_sh - DIVISOR : resto_sh);
          quoc <= {quoc[SOMA_W-2:0], cabe};
          passo <= passo + PW'(1);
          if (passo == PW'(SOMA_W - 1)) estado <= CLASSIFICA;
        end
        CLASSIFICA: begin
          media <= media_nova;
          medida_classificacao <= classe;
          descartar_medida <= (maior - menor) > LIMITE;
          fim_classificacao <= 1'b1;
          estado <= FIM;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_classificador_medida_n.sv
// tb_classificador_medida_n: scoreboard bench for the N-sample classifier (N=3 and N=5 instances).
module tb_classificador_medida_n;
  logic clock = 0, zera = 1, iniciar = 0, medida_valida = 0;
  logic [11:0] medida = 0, nv_baixo = 200, nv_alto = 50, nv_crit = 20;
  logic [11:0] media3, media5, media_s;
  logic [2:0] cls3, cls5, cls_s;
  logic desc3, desc5, desc_s, fim3, fim5, fim_s, ocu3, ocu5, ocu_s;
  bit sel5 = 0;
  int checks = 0, errors = 0;
  typedef struct packed {logic [11:0] m; logic [2:0] c; logic d;} exp_t;
  exp_t sb[$];
  always #5 clock = ~clock;
  classificador_medida_n #(.LARGURA(12), .N_AMOSTRAS(3), .MAX_DIFF(4)) u3 (
    .clock(clock), .zera(zera), .iniciar(iniciar), .medida_valida(medida_valida), .medida(medida),
    .nv_baixo(nv_baixo), .nv_alto(nv_alto), .nv_crit(nv_crit), .media(media3),
    .medida_classificacao(cls3), .descartar_medida(desc3), .fim_classificacao(fim3), .ocupado(ocu3));
  classificador_medida_n #(.LARGURA(12), .N_AMOSTRAS(5), .MAX_DIFF(4)) u5 (
    .clock(clock), .zera(zera), .iniciar(iniciar), .medida_valida(medida_valida), .medida(medida),
    .nv_baixo(nv_baixo), .nv_alto(nv_alto), .nv_crit(nv_crit), .media(media5),
    .medida_classificacao(cls5), .descartar_medida(desc5), .fim_classificacao(fim5), .ocupado(ocu5));
  assign media_s = sel5 ? media5 : media3;
  assign cls_s = sel5 ? cls5 : cls3;
  assign desc_s = sel5 ? desc5 : desc3;
  assign fim_s = sel5 ? fim5 : fim3;
  assign ocu_s = sel5 ? ocu5 : ocu3;
  function automatic logic [2:0] ref_cls(input logic [11:0] m, b, a, c);
    if (m > b) return 3'b001;
    if (a < m && m <= b) return 3'b100;
    if (c <= m && m <= a) return 3'b010;
    return 3'b011;
  endfunction
  task automatic do_run(input int n, input int s[5], input int gap, input bit hold, input int lat);
    int sum = 0, mx = 0, mn = 4095, k = 0;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      sum += s[i];
      mx = (s[i] > mx) ? s[i] : mx;
      mn = (s[i] < mn) ? s[i] : mn;
    end
    e.m = 12'(sum / n);
    e.c = ref_cls(e.m, nv_baixo, nv_alto, nv_crit);
    e.d = (mx - mn) > 4;
    sb.push_back(e);
    @(negedge clock) iniciar = 1;
    @(negedge clock) iniciar = hold;
    for (int i = 0; i < n; i++) begin
      medida = 12'(s[i]);
      medida_valida = 1;
      @(negedge clock) medida_valida = 0;
      if (i < n - 1) repeat (gap) @(negedge clock);
    end
    while (!fim_s && k < 200) begin
      @(negedge clock);
      k++;
      if (k == 3) begin
        checks++;
        if (ocu_s !== 1'b1) begin errors++; $display("FAIL ocupado_divide got=%b want=1", ocu_s); end
      end
    end
    checks++;
    if (!fim_s) begin errors++; $display("FAIL fim_timeout got=0 want=1 after %0d cycles", k); return; end
    e = sb.pop_front();
    checks += 3;
    if (media_s !== e.m) begin errors++; $display("FAIL media got=%0d want=%0d", media_s, e.m); end
    if (cls_s !== e.c) begin errors++; $display("FAIL classe got=%b want=%b", cls_s, e.c); end
    if (desc_s !== e.d) begin errors++; $display("FAIL descartar got=%b want=%b", desc_s, e.d); end
    if (lat > 0) begin
      checks++;
      if (k != lat) begin errors++; $display("FAIL latencia got=%0d want=%0d", k, lat); end
    end
    @(negedge clock);
    checks++;
    if (fim_s !== 1'b0) begin errors++; $display("FAIL fim_largura got=%b want=0", fim_s); end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clock);
    zera = 0;
    checks += 5;
    if (media3 !== 0) begin errors++; $display("FAIL reset_media got=%0d want=0", media3); end
    if (cls3 !== 0) begin errors++; $display("FAIL reset_classe got=%b want=000", cls3); end
    if (desc3 !== 0) begin errors++; $display("FAIL reset_descartar got=%b want=0", desc3); end
    if (fim3 !== 0) begin errors++; $display("FAIL reset_fim got=%b want=0", fim3); end
    if (ocu3 !== 0) begin errors++; $display("FAIL reset_ocupado got=%b want=0", ocu3); end
  endtask
  task automatic test_back_to_back();
    do_run(3, '{100, 102, 104, 0, 0}, 0, 0, 15);
  endtask
  task automatic test_gaps();
    do_run(3, '{100, 105, 100, 0, 0}, 2, 0, 0);
  endtask
  task automatic test_overflow();
    nv_baixo = 4000;
    do_run(3, '{4095, 4095, 4095, 0, 0}, 0, 0, 15);
  endtask
  task automatic test_boundaries();
    int v[5] = '{200, 100, 50, 49, 201};
    nv_baixo = 200; nv_alto = 100; nv_crit = 50;
    for (int i = 0; i < 5; i++) do_run(3, '{v[i], v[i], v[i], 0, 0}, 1, 0, 0);
  endtask
  task automatic test_zera_mid();
    @(negedge clock) iniciar = 1;
    @(negedge clock) iniciar = 0;
    for (int i = 0; i < 2; i++) begin
      medida = 12'(500 + i);
      medida_valida = 1;
      @(negedge clock) medida_valida = 0;
    end
    checks++;
    if (ocu3 !== 1'b1) begin errors++; $display("FAIL ocupado_coleta got=%b want=1", ocu3); end
    zera = 1;
    @(negedge clock) zera = 0;
    checks += 5;
    if (media3 !== 0) begin errors++; $display("FAIL zera_media got=%0d want=0", media3); end
    if (cls3 !== 0) begin errors++; $display("FAIL zera_classe got=%b want=000", cls3); end
    if (desc3 !== 0) begin errors++; $display("FAIL zera_descartar got=%b want=0", desc3); end
    if (fim3 !== 0) begin errors++; $display("FAIL zera_fim got=%b want=0", fim3); end
    if (ocu3 !== 0) begin errors++; $display("FAIL zera_ocupado got=%b want=0", ocu3); end
    do_run(3, '{10, 20, 30, 0, 0}, 0, 0, 15);
  endtask
  task automatic test_iniciar_held_n5();
    zera = 1;
    @(negedge clock) zera = 0;
    sel5 = 1;
    do_run(5, '{10, 11, 12, 13, 15}, 0, 1, 16);
    iniciar = 0;
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_boundaries();
    test_zera_mid();
    test_iniciar_held_n5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
